// File: rtl/ysyx_22050039_wbu.sv
// rtl/ysyx_22050039_wbu.sv - write-back unit: result FIFO, 32x XLEN regfile, forwarding read ports, commit trace
module ysyx_22050039_wbu #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [4:0]      i_in_rd,
  input  logic            i_in_wen,
  input  logic [XLEN-1:0] i_in_data,
  input  logic            i_wb_stall,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_commit_valid,
  output logic [4:0]      o_commit_rd,
  output logic [XLEN-1:0] o_commit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic            r_fifo_wen  [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_regs [32];

  logic w_push;
  logic w_pop;
  logic w_head_writes;

  assign o_in_ready    = rst && (r_count != CW'(DEPTH));
  assign w_push        = i_in_valid && o_in_ready;
  assign w_pop         = rst && (r_count != '0) && !i_wb_stall;
  assign w_head_writes = r_fifo_wen[r_rptr] && (r_fifo_rd[r_rptr] != 5'd0);

  // Walk pending entries oldest to youngest so the youngest match wins.
  function automatic logic [XLEN-1:0] f_read(input logic [4:0] a);
    logic [XLEN-1:0] v;
    logic [PW-1:0]   idx;
    v = r_regs[a];
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && r_fifo_wen[idx] && (r_fifo_rd[idx] == a))
        v = r_fifo_data[idx];
    end
    if (a == 5'd0)
      v = '0;
    return v;
  endfunction

  always_comb begin
    o_rs1_data = f_read(i_rs1_addr);
    o_rs2_data = f_read(i_rs2_addr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo_rd[r_wptr]   <= i_in_rd;
        r_fifo_wen[r_wptr]  <= i_in_wen;
        r_fifo_data[r_wptr] <= i_in_data;
        r_wptr              <= r_wptr + PW'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        r_regs[i] <= '0;
    end else if (w_pop && w_head_writes) begin
      r_regs[r_fifo_rd[r_rptr]] <= r_fifo_data[r_rptr];
    end
  end

  // Trace pulse is registered; rd/data are zeroed for slots that wrote nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_commit_valid <= 1'b0;
      o_commit_rd    <= '0;
      o_commit_data  <= '0;
    end else if (w_pop) begin
      o_commit_valid <= 1'b1;
      o_commit_rd    <= w_head_writes ? r_fifo_rd[r_rptr] : 5'd0;
      o_commit_data  <= w_head_writes ? r_fifo_data[r_rptr] : '0;
    end else begin
      o_commit_valid <= 1'b0;
    end
  end

endmodule
